// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage that sits after the ALU-control decoder.
// It computes AND/OR/ADD/SUB on two operands. Results are held in a 2-entry
// skid buffer (HEAD drives out_*, SKID absorbs one extra op) so out_ready
// never reaches in_ready combinationally.
// Optional build macro ALU_STATS_EN adds the stat_ops/stat_stall counters.
// state_dbg exposes the occupancy FSM (0 EMPTY, 1 ONE, 2 FULL).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holding valid keeps its payload stable until the
// transfer. in_ready is a registered function of the FSM state alone.
module alu_exec_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_alu_ctrl,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_wen,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic [RD_W-1:0] out_rd,
  output logic            out_wen,
  output logic            out_illegal,
  output logic            err_sticky,
`ifdef ALU_STATS_EN
  output logic [31:0]     stat_ops,
  output logic [31:0]     stat_stall,
`endif
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic [RD_W-1:0] rd;
    logic            wen;
    logic            illegal;
  } entry_t;

  state_t state, state_n;
  entry_t head, skid, new_entry;
  logic   in_ready_q;
  logic   in_xfer, out_xfer;
  logic   load_head_new, load_skid, move_skid;

  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;
  assign state_dbg = state;

  assign out_result  = head.result;
  assign out_zero    = head.zero;
  assign out_rd      = head.rd;
  assign out_wen     = head.wen;
  assign out_illegal = head.illegal;

  // Compute the candidate entry from the issue-side inputs.
  always_comb begin
    new_entry         = '0;
    new_entry.rd      = in_rd;
    new_entry.illegal = 1'b0;
    case (in_alu_ctrl)
      4'b0000: new_entry.result = in_a & in_b;
      4'b0001: new_entry.result = in_a | in_b;
      4'b0010: new_entry.result = in_a + in_b;
      4'b0011: new_entry.result = in_a - in_b;
      default: begin
        new_entry.result  = '0;
        new_entry.illegal = 1'b1;
      end
    endcase
    new_entry.zero = (new_entry.result == '0);
    new_entry.wen  = in_wen & ~new_entry.illegal;
  end

  // Next-state and buffer-steering decisions for the occupancy FSM.
  always_comb begin
    state_n       = state;
    load_head_new = 1'b0;
    load_skid     = 1'b0;
    move_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          load_head_new = 1'b1;
          state_n       = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_head_new = 1'b1;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          state_n   = FULL;
        end else if (out_xfer) begin
          state_n = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          move_skid = 1'b1;
          state_n   = ONE;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  // State, registered in_ready, storage entries and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b0;
      head       <= '0;
      skid       <= '0;
      err_sticky <= 1'b0;
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n != FULL);
      if (load_head_new) head <= new_entry;
      else if (move_skid) head <= skid;
      if (load_skid) skid <= new_entry;
      if (in_xfer && new_entry.illegal) err_sticky <= 1'b1;
    end
  end

`ifdef ALU_STATS_EN
  // Completed-result and back-pressure counters; both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      if (out_xfer) stat_ops <= stat_ops + 32'd1;
      if (out_valid && !out_ready) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed and randomized checks of alu_exec_stage.
// The reference is an in-order queue of expected results plus an occupancy
// count derived from the queue length.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alu_ctrl;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_illegal;
  logic        err_sticky;
  logic [1:0]  state_dbg;
`ifdef ALU_STATS_EN
  logic [31:0] stat_ops, stat_stall;
  logic [31:0] exp_ops, exp_stall;
`endif

  int total = 0;
  int bad   = 0;

  logic [39:0] exp_q[$];
  bit          exp_err;
  bit          hold_on;
  logic [39:0] hold_v;

  // clock / reset block
  always #5 clk = ~clk;

  alu_exec_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_ctrl(in_alu_ctrl), .in_a(in_a), .in_b(in_b),
    .in_rd(in_rd), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_rd(out_rd),
    .out_wen(out_wen), .out_illegal(out_illegal), .err_sticky(err_sticky),
`ifdef ALU_STATS_EN
    .stat_ops(stat_ops), .stat_stall(stat_stall),
`endif
    .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {illegal, wen, rd, zero, result}
  function automatic logic [39:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] rd,
                                        input logic wen);
    logic [31:0] r;
    logic        ill;
    ill = (c > 4'd3);
    r   = 32'd0;
    if (c == 4'd0) r = a & b;
    if (c == 4'd1) r = a | b;
    if (c == 4'd2) r = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
    if (c == 4'd3) r = 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
    return {ill, wen & ~ill, rd, (r == 32'd0), r};
  endfunction

  // One clock cycle, called at a negedge with inputs already applied.
  task automatic tick();
    logic [39:0] got, e;
    got = {out_illegal, out_wen, out_rd, out_zero, out_result};
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
    check("err_sticky", 64'(err_sticky), 64'(exp_err));
`ifdef ALU_STATS_EN
    check("stat_ops", 64'(stat_ops), 64'(exp_ops));
    check("stat_stall", 64'(stat_stall), 64'(exp_stall));
    if (out_valid && out_ready) exp_ops++;
    if (out_valid && !out_ready) exp_stall++;
`endif
    if (hold_on) check("hold_stable", 64'(got), 64'(hold_v));
    hold_on = out_valid && !out_ready;
    hold_v  = got;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("extra_output", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check("result_order", 64'(got), 64'(e));
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(in_alu_ctrl, in_a, in_b, in_rd, in_wen));
      if (in_alu_ctrl > 4'd3) exp_err = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // driver: present one op and hold it until accepted
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic wen);
    bit acc;
    acc = 0;
    in_valid = 1'b1; in_alu_ctrl = c; in_a = a; in_b = b; in_rd = rd; in_wen = wen;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = in_ready;
      tick();
    end
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_result", 64'(out_result), 64'd0);
    check("rst_zero", 64'(out_zero), 64'd0);
    check("rst_rd", 64'(out_rd), 64'd0);
    check("rst_wen", 64'(out_wen), 64'd0);
    check("rst_illegal", 64'(out_illegal), 64'd0);
    check("rst_err", 64'(err_sticky), 64'd0);
`ifdef ALU_STATS_EN
    check("rst_stat_ops", 64'(stat_ops), 64'd0);
    check("rst_stat_stall", 64'(stat_stall), 64'd0);
    exp_ops = 0; exp_stall = 0;
`endif
    rst = 1'b0;
    exp_q.delete();
    exp_err = 0;
    hold_on = 0;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    logic [3:0]  c;
    logic [31:0] a, b;
    rst = 1'b1; in_valid = 1'b0; in_alu_ctrl = '0; in_a = '0; in_b = '0;
    in_rd = '0; in_wen = 1'b0; out_ready = 1'b1;
    exp_err = 0; hold_on = 0;
`ifdef ALU_STATS_EN
    exp_ops = 0; exp_stall = 0;
`endif
    @(negedge clk);
    do_reset();

    // back-to-back ADD / SUB / OR
    out_ready = 1'b1;
    issue(4'h2, 32'd5, 32'd7, 5'd1, 1'b1);
    check("add_5_7", 64'(out_result), 64'd12);
    check("add_zero", 64'(out_zero), 64'd0);
    issue(4'h3, 32'd3, 32'd3, 5'd2, 1'b1);
    check("sub_3_3", 64'(out_result), 64'd0);
    check("sub_zero", 64'(out_zero), 64'd1);
    issue(4'h1, 32'hF0, 32'h0F, 5'd3, 1'b1);
    check("or_f0_0f", 64'(out_result), 64'hFF);
    drain();

    // wrap-around
    issue(4'h3, 32'd0, 32'd1, 5'd4, 1'b1);
    check("sub_wrap", 64'(out_result), 64'hFFFF_FFFF);
    issue(4'h2, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
    check("add_wrap", 64'(out_result), 64'd0);
    check("add_wrap_zero", 64'(out_zero), 64'd1);
    drain();

    // stall with full buffer
    out_ready = 1'b0;
    issue(4'h0, 32'hFF, 32'h0F, 5'd6, 1'b1);
    issue(4'h2, 32'd1, 32'd1, 5'd7, 1'b1);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_state_full", 64'(state_dbg), 64'd2);
    tick(); tick();
    check("stall_hold_0f", 64'(out_result), 64'h0F);
    drain();
    check("stall_ready_back", 64'(in_ready), 64'd1);

    // illegal op and sticky error
    issue(4'hF, 32'h1234, 32'h5678, 5'd8, 1'b1);
    check("ill_flag", 64'(out_illegal), 64'd1);
    check("ill_wen", 64'(out_wen), 64'd0);
    check("ill_result", 64'(out_result), 64'd0);
    check("ill_zero", 64'(out_zero), 64'd1);
    drain();
    issue(4'h2, 32'd9, 32'd9, 5'd9, 1'b1);
    drain();
    check("err_still_set", 64'(err_sticky), 64'd1);
    do_reset();

    // simultaneous in/out for 10 ops
    out_ready = 1'b1;
    issue(4'h2, 32'd100, 32'd0, 5'd10, 1'b1);
    for (int i = 0; i < 10; i++) begin
      issue(4'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 31)), 1'b1);
      check("sim_not_full", 64'(state_dbg == 2'd2), 64'd0);
    end
    drain();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      a = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
      b = ($urandom_range(0, 4) == 0) ? a : $urandom;
      // keep a pending op stable until it is accepted
      if (!(in_valid && !in_ready)) begin
        in_valid = 1'($urandom_range(0, 1)); in_alu_ctrl = c; in_a = a; in_b = b;
        in_rd = 5'($urandom_range(0, 31)); in_wen = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();

    // reset while FULL discards buffered ops
    out_ready = 1'b0;
    issue(4'hA, 32'd1, 32'd2, 5'd11, 1'b1);
    issue(4'h2, 32'd3, 32'd4, 5'd12, 1'b1);
    check("pre_rst_full", 64'(state_dbg), 64'd2);
    check("pre_rst_err", 64'(err_sticky), 64'd1);
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
